bus_trace_capture: RTL

Synthesisable 6502 bus-trace capture for the Atom FPGA boards. Samples a parametrised trace word (address/data/control taps) on every falling edge of phi2, filters by free-run or masked-trigger mode, and buffers samples in an on-chip FIFO. The FIFO drains through a valid/ready stream to a UART or debug bridge. This replaces simulation-only `$display` tracing with hardware capture on the Tang Nano 9K and related targets.

---
 rtl/bus_trace_pkg.sv | 16 +
 rtl/trace_fifo.sv | 70 +++++++
 rtl/bus_trace_capture.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bus_trace_pkg.sv
// Shared encodings and helpers for the 6502 bus-trace capture block.
// Pure declarations, no logic.
package bus_trace_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] STREAM  = 3'd1;
  localparam logic [2:0] ARMED   = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  // A requested capture length of zero means "fill the whole buffer".
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned depth_log2);
    return (len == 0) ? (32'd1 << depth_log2) : len;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO: RAM plus output register; write-to-rd_vld latency 1 cycle when empty.
// Writes while full are ignored (caller counts them); rd_dat holds steady until rd_rdy.
module trace_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_vld,
  input  logic [WIDTH-1:0]      wr_dat,
  output logic                  rd_vld,
  output logic [WIDTH-1:0]      rd_dat,
  input  logic                  rd_rdy,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   fill
);

  localparam int PW = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_nxt;
  logic             wr_en;
  logic             pop;
  logic             have_next;

  // rd_ptr counts words handed to the consumer, so the output register is
  // part of the occupancy and full/empty fall straight out of the pointers.
  assign full       = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign fill       = wr_ptr - rd_ptr;
  assign wr_en      = wr_vld && !full && !flush;
  assign pop        = rd_vld && rd_rdy;
  assign rd_ptr_nxt = rd_ptr + PW'(pop);
  assign have_next  = (wr_ptr != rd_ptr_nxt);

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr[PW-2:0]] <= wr_dat;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_vld <= 1'b0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      rd_vld <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      rd_vld <= have_next;
    end
  end

  // Reload the head only when it is empty or being taken this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_dat <= '0;
    end else if (!flush && have_next && (!rd_vld || pop)) begin
      rd_dat <= mem[rd_ptr_nxt[PW-2:0]];
    end
  end

endmodule

// File: rtl/bus_trace_capture.sv
// Samples the trace word on each phi2 fall, filters by free-run/trigger mode, buffers in a FIFO.
// phi2 fall to out_valid is 5 clocks; a full FIFO drops samples and counts them, out_ready stalls the head.
module bus_trace_capture
  import bus_trace_pkg::*;
#(
  parameter int TRACE_WIDTH = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int DROP_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   phi2,
  input  logic [TRACE_WIDTH-1:0] trace_in,
  input  logic                   arm,
  input  logic                   mode,
  input  logic                   flush,
  input  logic [TRACE_WIDTH-1:0] trig_value,
  input  logic [TRACE_WIDTH-1:0] trig_mask,
  input  logic [DEPTH_LOG2:0]    capture_len,
  output logic [TRACE_WIDTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             state,
  output logic [DEPTH_LOG2:0]    fill,
  output logic [DROP_WIDTH-1:0]  dropped
);

  localparam int LW = DEPTH_LOG2 + 1;

  logic                   s1, s2, s3;
  logic                   strobe;
  logic [TRACE_WIDTH-1:0] t1, t2, t3;
  logic                   strobe_ok;
  logic                   hit;
  logic                   want_wr;
  logic                   full;
  logic [2:0]             state_q;
  logic [LW-1:0]          len_q;
  logic [LW-1:0]          cnt_q;
  logic [LW-1:0]          cnt_inc;

  // Sync flops idle high so leaving reset never fakes a falling edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s3     <= 1'b1;
      strobe <= 1'b0;
      t1     <= '0;
      t2     <= '0;
      t3     <= '0;
    end else begin
      s1     <= phi2;
      s2     <= s1;
      s3     <= s2;
      strobe <= s3 && !s2;
      t1     <= trace_in;
      t2     <= t1;
      t3     <= t2;
    end
  end

  assign strobe_ok = strobe && !flush;
  assign hit       = ((t3 ^ trig_value) & trig_mask) == '0;
  assign cnt_inc   = cnt_q + LW'(1);

  always_comb begin
    want_wr = 1'b0;
    case (state_q)
      STREAM, CAPTURE: want_wr = strobe_ok;
      ARMED:           want_wr = strobe_ok && hit;
      default:         want_wr = 1'b0;
    endcase
  end

  // arm overrides whatever the current state would otherwise do this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else if (arm) begin
      state_q <= mode ? ARMED : STREAM;
      cnt_q   <= '0;
      len_q   <= LW'(eff_len(32'(capture_len), int'(DEPTH_LOG2)));
    end else begin
      case (state_q)
        ARMED: begin
          if (strobe_ok && hit) begin
            cnt_q   <= LW'(1);
            state_q <= (len_q == LW'(1)) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (strobe_ok) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == len_q) begin
              state_q <= DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      dropped <= '0;
    end else if (want_wr && full && (dropped != '1)) begin
      dropped <= dropped + DROP_WIDTH'(1);
    end
  end

  assign state = state_q;

  trace_fifo #(
    .WIDTH      (TRACE_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .flush  (flush),
    .wr_vld (want_wr),
    .wr_dat (t3),
    .rd_vld (out_valid),
    .rd_dat (out_data),
    .rd_rdy (out_ready),
    .full   (full),
    .fill   (fill)
  );

endmodule
